redirect_sequencer: RTL and testbench
=====================================

Name: redirect_sequencer

Overview:
- Sequences every control-flow redirect in the 6-stage in-order core (IF, DC, EX, EX2, MEM, WB).
- Qualifies WB trap, return, CSR and fence.i events, plus EX2 taken branches, and drives the per-stage flush lines.
- Emits a registered redirect PC pulse to IF.
- Runs the multi-cycle fence.i sequence: D-cache drain, then I-cache invalidate, then redirect. IF is held stalled for the whole sequence.

Parameters:
- XLEN, 32, datapath/PC width.
- RESET_VECTOR, 32'h8000_0000, value of redirect_pc after reset.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; asynchronous, active-high.
- cancel_wb  in  1  WB instruction cancelled; masks all WB events.
- irq_taken  in  1  interrupt accepted this cycle.
- ecall_wb  in  1  ecall in WB.
- mret_wb  in  1  mret in WB.
- fencei_wb  in  1  fence.i in WB.
- csr_wr_wb  in  1  CSR write in WB.
- pc_wb  in  XLEN  PC of WB instruction.
- mtvec  in  XLEN  trap vector.
- mepc  in  XLEN  return PC.
- branch_taken_ex2  in  1  taken branch or jump resolved in EX2.
- branch_target_ex2  in  XLEN  branch target.
- dcache_drain_req  out  1  request D-cache writeback drain.
- dcache_drain_done  in  1  drain complete, 1-cycle pulse or level.
- icache_inv_req  out  1  request I-cache invalidate.
- icache_inv_ack  in  1  invalidate complete.
- flush_if, flush_dc, flush_ex, flush_ex2, flush_mem  out  1 each  stage flushes.
- redirect_valid  out  1  one-cycle redirect pulse to IF.
- redirect_pc  out  XLEN  redirect target.
- stall_if  out  1  hold IF.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async): state=IDLE, redirect_valid=0, redirect_pc=RESET_VECTOR, all request outputs 0. Flush, stall and busy outputs are 0 while in IDLE with no event present.
- WB event qualification: wb_evt = (irq_taken | ((ecall_wb|mret_wb|fencei_wb|csr_wr_wb) & !cancel_wb)).
- irq_taken is never masked by cancel_wb.
- Priority: irq > ecall > mret > fencei > csr > branch.
- Targets:
  - irq, ecall: mtvec.
  - mret: mepc.
  - csr, fencei: pc_wb+4, truncated to XLEN, wraps modulo 2^XLEN.
  - branch: branch_target_ex2.
- Flush lines are combinational in IDLE.
  - Any wb_evt in cycle N: all five flushes =1 in cycle N.
  - Else branch_taken_ex2: flush_if, flush_dc and flush_ex =1; flush_ex2 and flush_mem =0.
- Non-fence redirects: target registered at the edge ending cycle N. redirect_valid=1 for exactly cycle N+1 with redirect_pc=target. State stays IDLE. redirect_pc holds its last value afterwards.
- A WB event and an EX2 branch in the same cycle: the WB event wins and the branch is dropped (it is flushed).
- States: IDLE, DRAIN, INVAL, REDIR.
- fencei wins arbitration in cycle N:
  - All flushes =1 in cycle N.
  - pc_wb+4 is saved.
  - Next state DRAIN.
- DRAIN:
  - dcache_drain_req=1; all flushes=1; stall_if=1; busy=1.
  - On dcache_drain_done=1, go to INVAL.
  - dcache_drain_req falls the cycle after done is sampled.
- INVAL:
  - icache_inv_req=1; flushes, stall_if and busy as in DRAIN.
  - On icache_inv_ack=1, go to REDIR.
- REDIR:
  - redirect_valid=1, redirect_pc=saved PC; flushes=1; busy=1.
  - Next state IDLE.
- Handshake inputs are ignored outside their own state: done outside DRAIN, ack outside INVAL.
- No timeout; the sequencer waits indefinitely.
- All WB and branch inputs are ignored while busy.
- The interrupt controller must not assert irq_taken while busy=1. If it does, the irq is dropped and no redirect results.
- rst mid-sequence: immediate return to IDLE, requests deassert asynchronously, redirect_pc=RESET_VECTOR.

Test Plan:
- ecall_wb=1, mtvec=32'h100, cycle N -> all flushes=1 in N; redirect_valid=1 with redirect_pc=32'h100 in N+1 only.
- branch_taken_ex2=1, target=32'h2000, no WB event -> flush_if/dc/ex=1 and flush_ex2/mem=0 in N; redirect to 32'h2000 in N+1.
- Same cycle: mret_wb=1 (mepc=32'h40) and branch_taken_ex2=1 (target 32'h2000) -> redirect 32'h40; no second redirect.
- fencei_wb=1, pc_wb=32'h1FFC; drain_done after 3 cycles; ack after 2 cycles -> drain_req high 3 cycles, then inv_req high 2 cycles, then redirect_valid with 32'h2000. busy and stall_if are high throughout the sequence.
- ecall_wb=1 with cancel_wb=1 -> no flush, no redirect. irq_taken=1 with cancel_wb=1 -> redirect to mtvec.
- Assert rst while in INVAL -> icache_inv_req=0, state=IDLE and redirect_pc=RESET_VECTOR immediately. A later fencei sequence completes normally. pc_wb=32'hFFFF_FFFC csr_wr_wb -> redirect 32'h0.

Source files
------------

// File: rtl/redirect_sequencer.sv
// Control-flow redirect sequencer for the 6-stage in-order core: qualifies WB/EX2
// redirect events, drives stage flushes, and runs the fence.i drain/invalidate sequence.
module redirect_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cancel_wb,
  input  logic            irq_taken,
  input  logic            ecall_wb,
  input  logic            mret_wb,
  input  logic            fencei_wb,
  input  logic            csr_wr_wb,
  input  logic [XLEN-1:0] pc_wb,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            branch_taken_ex2,
  input  logic [XLEN-1:0] branch_target_ex2,
  output logic            dcache_drain_req,
  input  logic            dcache_drain_done,
  output logic            icache_inv_req,
  input  logic            icache_inv_ack,
  output logic            flush_if,
  output logic            flush_dc,
  output logic            flush_ex,
  output logic            flush_ex2,
  output logic            flush_mem,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            stall_if,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, DRAIN, INVAL, REDIR} state_t;

  state_t          state, state_nxt;
  logic            ecall_q, mret_q, fencei_q, csr_q, wb_evt;
  logic            evt_valid, evt_fence;
  logic [XLEN-1:0] evt_target, pc_next, saved_pc;

  // Event qualification and priority arbitration; only meaningful while IDLE.
  always_comb begin
    ecall_q    = ecall_wb  & ~cancel_wb;
    mret_q     = mret_wb   & ~cancel_wb;
    fencei_q   = fencei_wb & ~cancel_wb;
    csr_q      = csr_wr_wb & ~cancel_wb;
    wb_evt     = irq_taken | ecall_q | mret_q | fencei_q | csr_q;
    pc_next    = pc_wb + XLEN'(4);
    evt_valid  = 1'b0;
    evt_fence  = 1'b0;
    evt_target = '0;
    if (state == IDLE) begin
      if (irq_taken | ecall_q) begin
        evt_valid  = 1'b1;
        evt_target = mtvec;
      end else if (mret_q) begin
        evt_valid  = 1'b1;
        evt_target = mepc;
      end else if (fencei_q) begin
        evt_fence  = 1'b1;
      end else if (csr_q) begin
        evt_valid  = 1'b1;
        evt_target = pc_next;
      end else if (branch_taken_ex2) begin
        evt_valid  = 1'b1;
        evt_target = branch_target_ex2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (evt_fence)         state_nxt = DRAIN;
      DRAIN:   if (dcache_drain_done) state_nxt = INVAL;
      INVAL:   if (icache_inv_ack)    state_nxt = REDIR;
      REDIR:                          state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dcache_drain_req = 1'b0;
    icache_inv_req   = 1'b0;
    flush_if         = 1'b0;
    flush_dc         = 1'b0;
    flush_ex         = 1'b0;
    flush_ex2        = 1'b0;
    flush_mem        = 1'b0;
    stall_if         = 1'b0;
    busy             = 1'b0;
    if (state == IDLE) begin
      flush_if  = wb_evt | branch_taken_ex2;
      flush_dc  = wb_evt | branch_taken_ex2;
      flush_ex  = wb_evt | branch_taken_ex2;
      flush_ex2 = wb_evt;
      flush_mem = wb_evt;
    end else begin
      dcache_drain_req = (state == DRAIN);
      icache_inv_req   = (state == INVAL);
      flush_if         = 1'b1;
      flush_dc         = 1'b1;
      flush_ex         = 1'b1;
      flush_ex2        = 1'b1;
      flush_mem        = 1'b1;
      stall_if         = 1'b1;
      busy             = 1'b1;
    end
  end

  // The fence.i redirect is launched on the INVAL->REDIR edge so it is registered like the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= RESET_VECTOR;
      saved_pc       <= '0;
    end else begin
      redirect_valid <= 1'b0;
      if (evt_valid) begin
        redirect_valid <= 1'b1;
        redirect_pc    <= evt_target;
      end else if (state == INVAL && icache_inv_ack) begin
        redirect_valid <= 1'b1;
        redirect_pc    <= saved_pc;
      end
      if (evt_fence) saved_pc <= pc_next;
    end
  end

endmodule

// File: tb/tb_redirect_sequencer.sv
// Directed bench for redirect_sequencer: table of single-cycle redirect events plus
// hand-written fence.i and reset-during-sequence scenarios.
module tb_redirect_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cancel_wb, irq_taken, ecall_wb, mret_wb, fencei_wb, csr_wr_wb;
  logic [31:0] pc_wb, mtvec, mepc, branch_target_ex2;
  logic        branch_taken_ex2;
  logic        dcache_drain_req, dcache_drain_done, icache_inv_req, icache_inv_ack;
  logic        flush_if, flush_dc, flush_ex, flush_ex2, flush_mem;
  logic        redirect_valid, stall_if, busy;
  logic [31:0] redirect_pc;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  redirect_sequencer #(.XLEN(32), .RESET_VECTOR(32'h8000_0000)) dut (
    .clk(clk), .rst(rst), .cancel_wb(cancel_wb), .irq_taken(irq_taken),
    .ecall_wb(ecall_wb), .mret_wb(mret_wb), .fencei_wb(fencei_wb), .csr_wr_wb(csr_wr_wb),
    .pc_wb(pc_wb), .mtvec(mtvec), .mepc(mepc),
    .branch_taken_ex2(branch_taken_ex2), .branch_target_ex2(branch_target_ex2),
    .dcache_drain_req(dcache_drain_req), .dcache_drain_done(dcache_drain_done),
    .icache_inv_req(icache_inv_req), .icache_inv_ack(icache_inv_ack),
    .flush_if(flush_if), .flush_dc(flush_dc), .flush_ex(flush_ex),
    .flush_ex2(flush_ex2), .flush_mem(flush_mem),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_if(stall_if), .busy(busy)
  );

  always #5 clk = ~clk;

  // {flush_if,dc,ex,ex2,mem, drain_req, inv_req, stall_if, busy, redirect_valid}
  logic [9:0] obs;
  assign obs = {flush_if, flush_dc, flush_ex, flush_ex2, flush_mem,
                dcache_drain_req, icache_inv_req, stall_if, busy, redirect_valid};

  localparam logic [9:0] OBS_IDLE  = 10'b00000_0_0_0_0_0;
  localparam logic [9:0] OBS_DRAIN = 10'b11111_1_0_1_1_0;
  localparam logic [9:0] OBS_INVAL = 10'b11111_0_1_1_1_0;

  typedef struct {
    logic        irq, ecall, mret, csr, cancel, br;
    logic [31:0] pc, tvec, epc, tgt;
    logic [4:0]  exp_flush;
    logic        exp_redir;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic clear_inputs();
    cancel_wb = 0; irq_taken = 0; ecall_wb = 0; mret_wb = 0; fencei_wb = 0; csr_wr_wb = 0;
    branch_taken_ex2 = 0; dcache_drain_done = 0; icache_inv_ack = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  logic [31:0] last_pc;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //          irq ecall mret csr cancel br  pc            tvec          epc           tgt            flush     redir pc
    tbl[0] = '{0, 1, 0, 0, 0, 0, 32'h0,         32'h100,      32'h0,        32'h0,         5'b11111, 1, 32'h100};
    tbl[1] = '{0, 0, 0, 0, 0, 1, 32'h0,         32'h0,        32'h0,        32'h2000,      5'b11100, 1, 32'h2000};
    tbl[2] = '{0, 0, 1, 0, 0, 1, 32'h0,         32'h0,        32'h40,       32'h2000,      5'b11111, 1, 32'h40};
    tbl[3] = '{0, 1, 0, 0, 1, 0, 32'h0,         32'h100,      32'h0,        32'h0,         5'b00000, 0, 32'h0};
    tbl[4] = '{1, 0, 0, 0, 1, 0, 32'h0,         32'h100,      32'h0,        32'h0,         5'b11111, 1, 32'h100};
    tbl[5] = '{0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'h0,        32'h0,        32'h0,         5'b11111, 1, 32'h0};
    tbl[6] = '{1, 0, 1, 0, 0, 0, 32'h0,         32'h300,      32'h40,       32'h0,         5'b11111, 1, 32'h300};
    tbl[7] = '{0, 0, 1, 1, 0, 0, 32'h1000,      32'h0,        32'h44,       32'h0,         5'b11111, 1, 32'h44};
    tbl[8] = '{0, 0, 0, 1, 1, 1, 32'h1000,      32'h0,        32'h0,        32'h3000,      5'b11100, 1, 32'h3000};
    tbl[9] = '{0, 0, 0, 0, 0, 0, 32'h1000,      32'h0,        32'h0,        32'h3000,      5'b00000, 0, 32'h0};

    clear_inputs();
    pc_wb = 0; mtvec = 0; mepc = 0; branch_target_ex2 = 0;
    rst = 1;
    @(negedge clk);
    chk("reset_outputs", {22'b0, obs}, {22'b0, OBS_IDLE});
    chk("reset_pc", redirect_pc, 32'h8000_0000);
    step(); rst = 0;
    @(negedge clk);
    chk("post_reset_outputs", {22'b0, obs}, {22'b0, OBS_IDLE});

    last_pc = 32'h8000_0000;
    for (int i = 0; i < 10; i++) begin
      step();
      irq_taken = tbl[i].irq; ecall_wb = tbl[i].ecall; mret_wb = tbl[i].mret;
      csr_wr_wb = tbl[i].csr; cancel_wb = tbl[i].cancel; branch_taken_ex2 = tbl[i].br;
      pc_wb = tbl[i].pc; mtvec = tbl[i].tvec; mepc = tbl[i].epc; branch_target_ex2 = tbl[i].tgt;
      @(negedge clk);
      chk($sformatf("v%0d_flush", i), {27'b0, obs[9:5]}, {27'b0, tbl[i].exp_flush});
      chk($sformatf("v%0d_valid_N", i), {31'b0, redirect_valid}, 32'h0);
      chk($sformatf("v%0d_busy_N", i), {31'b0, busy}, 32'h0);
      step();
      clear_inputs();
      @(negedge clk);
      chk($sformatf("v%0d_valid_N1", i), {31'b0, redirect_valid}, {31'b0, tbl[i].exp_redir});
      if (tbl[i].exp_redir) last_pc = tbl[i].exp_pc;
      chk($sformatf("v%0d_pc_N1", i), redirect_pc, last_pc);
    end

    // fence.i: drain done after 3 cycles, ack after 2; WB/branch/irq noise held while busy.
    step();
    fencei_wb = 1; pc_wb = 32'h1FFC; mtvec = 32'h500; mepc = 32'h600;
    @(negedge clk);
    chk("fi_flush_N", {27'b0, obs[9:5]}, 32'h1F);
    chk("fi_valid_N", {31'b0, redirect_valid}, 32'h0);
    step();
    clear_inputs();
    ecall_wb = 1; irq_taken = 1; branch_taken_ex2 = 1; icache_inv_ack = 1;
    @(negedge clk);
    chk("fi_drain1", {22'b0, obs}, {22'b0, OBS_DRAIN});
    step(); icache_inv_ack = 0;
    @(negedge clk);
    chk("fi_drain2", {22'b0, obs}, {22'b0, OBS_DRAIN});
    step(); dcache_drain_done = 1;
    @(negedge clk);
    chk("fi_drain3", {22'b0, obs}, {22'b0, OBS_DRAIN});
    step(); dcache_drain_done = 0;
    @(negedge clk);
    chk("fi_inval1", {22'b0, obs}, {22'b0, OBS_INVAL});
    step(); icache_inv_ack = 1;
    @(negedge clk);
    chk("fi_inval2", {22'b0, obs}, {22'b0, OBS_INVAL});
    step();
    clear_inputs();
    @(negedge clk);
    chk("fi_redir_valid", {31'b0, redirect_valid}, 32'h1);
    chk("fi_redir_pc", redirect_pc, 32'h2000);
    chk("fi_redir_flush", {27'b0, obs[9:5]}, 32'h1F);
    chk("fi_redir_busy", {31'b0, busy}, 32'h1);
    chk("fi_redir_reqs", {30'b0, dcache_drain_req, icache_inv_req}, 32'h0);
    step();
    @(negedge clk);
    chk("fi_after_outputs", {22'b0, obs}, {22'b0, OBS_IDLE});
    chk("fi_after_pc", redirect_pc, 32'h2000);

    // Reset asserted while in INVAL.
    step();
    fencei_wb = 1; pc_wb = 32'h1FFC;
    step();
    fencei_wb = 0; dcache_drain_done = 1;
    @(negedge clk);
    chk("rs_drain", {22'b0, obs}, {22'b0, OBS_DRAIN});
    step(); dcache_drain_done = 0;
    @(negedge clk);
    chk("rs_inval", {22'b0, obs}, {22'b0, OBS_INVAL});
    #2 rst = 1;
    #1;
    chk("rs_async_outputs", {22'b0, obs}, {22'b0, OBS_IDLE});
    chk("rs_async_pc", redirect_pc, 32'h8000_0000);
    step(); rst = 0;
    icache_inv_ack = 1;
    @(negedge clk);
    chk("rs_stray_ack", {22'b0, obs}, {22'b0, OBS_IDLE});
    step(); icache_inv_ack = 0;
    @(negedge clk);
    chk("rs_stray_ack_after", {22'b0, obs}, {22'b0, OBS_IDLE});

    // Follow-up fence.i with immediate done/ack levels completes normally.
    step();
    fencei_wb = 1; pc_wb = 32'h10;
    step();
    fencei_wb = 0; dcache_drain_done = 1; icache_inv_ack = 1;
    @(negedge clk);
    chk("f2_drain", {22'b0, obs}, {22'b0, OBS_DRAIN});
    step();
    @(negedge clk);
    chk("f2_inval", {22'b0, obs}, {22'b0, OBS_INVAL});
    step();
    clear_inputs();
    @(negedge clk);
    chk("f2_redir_valid", {31'b0, redirect_valid}, 32'h1);
    chk("f2_redir_pc", redirect_pc, 32'h14);
    step();
    @(negedge clk);
    chk("f2_after_outputs", {22'b0, obs}, {22'b0, OBS_IDLE});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
